// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, a registered carry loop,
// and valid/ready handshakes on both the operand and result sides.

module full_adder (
    input  logic i_x,
    input  logic i_y,
    input  logic i_carry,
    output logic o_sum,
    output logic o_carry
);
    always_comb begin
        o_sum   = i_x ^ i_y ^ i_carry;
        o_carry = (i_x & i_y) | (i_carry & (i_x ^ i_y));
    end
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic             w_run;
    logic             w_last;

    full_adder u_fa (
        .i_x     (r_a_sh[0]),
        .i_y     (r_b_sh[0]),
        .i_carry (r_carry),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    always_comb begin
        w_run  = (r_state == S_RUN);
        w_last = w_run && (r_cnt == CNT_LAST);
    end

    // The sum shift register keeps only the WIDTH-1 bits already produced;
    // the completed word is those bits plus the cell's current o_sum.
    generate
        if (WIDTH == 1) begin : g_w1
            always_comb w_sum_next = w_fa_sum;
        end else begin : g_wn
            logic [WIDTH-2:0] r_sum_sh;
            always_comb w_sum_next = {w_fa_sum, r_sum_sh};
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_sum_sh <= '0;
                end else if (w_run) begin
                    r_sum_sh <= w_sum_next[WIDTH-1:1];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_DONE;
            S_DONE:  if (i_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state == S_IDLE);
        o_valid = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            o_sum   <= '0;
            o_carry <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a_sh  <= i_a;
                        r_b_sh  <= i_b;
                        r_carry <= i_carry;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_fa_carry;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        o_sum   <= w_sum_next;
                        o_carry <= w_fa_carry;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
